// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty core sequencing logic: instruction width,
// default halt word, sequencer state encodings and a saturating counter helper.
package bitty_pkg;

    localparam int INSTR_W = 16;
    localparam int RETIRED_W = 16;

    localparam logic [INSTR_W-1:0] HALT_INSTR_DEFAULT = 16'hFFFF;

    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_FETCH   = 3'd1,
        SEQ_EXEC    = 3'd2,
        SEQ_ADVANCE = 3'd3,
        SEQ_PAUSE   = 3'd4,
        SEQ_HALTED  = 3'd5
    } seq_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [RETIRED_W-1:0] sat_inc(input logic [RETIRED_W-1:0] value);
        logic [RETIRED_W-1:0] result;
        if (value == {RETIRED_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/instruction_sequencer.sv
// Top-level sequencer for the bitty core: fetches each instruction from program
// memory, holds run high while the control unit executes it, then advances pc.
// Adds run/halt, single-step, a retired-instruction counter and a done watchdog.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// SEQ_IDLE    | after reset, waiting for start
// SEQ_FETCH   | mem_req held with mem_addr = pc until mem_ack
// SEQ_EXEC    | run high, waiting for done; watchdog counting
// SEQ_ADVANCE | one cycle: bump retired and pc, decide halt/pause/fetch
// SEQ_PAUSE   | single-step hold; step pulse or step_mode low resumes
// SEQ_HALTED  | program finished or watchdog tripped; start restarts at 0
module instruction_sequencer
    import bitty_pkg::*;
#(
    parameter int                 ADDR_W     = 8,
    parameter logic [ADDR_W-1:0]  LAST_ADDR  = {ADDR_W{1'b1}},
    parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEFAULT,
    parameter int                 TIMEOUT    = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 step_mode,
    input  logic                 step,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [INSTR_W-1:0]   mem_rdata,
    input  logic                 mem_ack,
    output logic                 run,
    output logic [INSTR_W-1:0]   instr,
    input  logic                 done,
    output logic [ADDR_W-1:0]    pc,
    output logic                 busy,
    output logic                 halted,
    output logic                 error,
    output logic [RETIRED_W-1:0] retired
);

    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [WDOG_W-1:0] wdog;
    logic              wdog_expired;
    logic              last_retire;

    // The watchdog trips on the TIMEOUT-th EXEC cycle that still has no done,
    // so EXEC lasts at most TIMEOUT cycles.
    assign wdog_expired = (wdog == WDOG_W'(TIMEOUT - 1));
    assign last_retire  = (pc == LAST_ADDR) || (instr == HALT_INSTR);
    assign mem_addr     = pc;

    // Next-state selection; start/step/done/mem_ack only matter in their own states.
    always_comb begin
        state_nxt = state;
        case (state)
            SEQ_IDLE: begin
                if (start) state_nxt = SEQ_FETCH;
            end
            SEQ_FETCH: begin
                if (mem_ack) state_nxt = SEQ_EXEC;
            end
            SEQ_EXEC: begin
                if (done) begin
                    state_nxt = SEQ_ADVANCE;
                end else if (wdog_expired) begin
                    state_nxt = SEQ_HALTED;
                end
            end
            SEQ_ADVANCE: begin
                if (last_retire) begin
                    state_nxt = SEQ_HALTED;
                end else if (step_mode) begin
                    state_nxt = SEQ_PAUSE;
                end else begin
                    state_nxt = SEQ_FETCH;
                end
            end
            SEQ_PAUSE: begin
                if (step || !step_mode) state_nxt = SEQ_FETCH;
            end
            SEQ_HALTED: begin
                if (start) state_nxt = SEQ_FETCH;
            end
            default: begin
                state_nxt = SEQ_IDLE;
            end
        endcase
    end

    // State, datapath registers and registered Moore outputs (decoded from next state
    // so they line up with the state register; async reset clears them immediately).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SEQ_IDLE;
            pc      <= '0;
            instr   <= '0;
            retired <= '0;
            wdog    <= '0;
            error   <= 1'b0;
            run     <= 1'b0;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state   <= state_nxt;
            run     <= (state_nxt == SEQ_EXEC);
            mem_req <= (state_nxt == SEQ_FETCH);
            busy    <= (state_nxt == SEQ_FETCH) || (state_nxt == SEQ_EXEC) ||
                       (state_nxt == SEQ_ADVANCE);
            halted  <= (state_nxt == SEQ_HALTED);

            case (state)
                SEQ_IDLE, SEQ_HALTED: begin
                    if (start) begin
                        pc      <= '0;
                        retired <= '0;
                        error   <= 1'b0;
                    end
                end
                SEQ_FETCH: begin
                    if (mem_ack) begin
                        instr <= mem_rdata;
                        wdog  <= '0;
                    end
                end
                SEQ_EXEC: begin
                    if (!done) begin
                        if (wdog_expired) begin
                            error <= 1'b1;
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
                    end
                end
                SEQ_ADVANCE: begin
                    retired <= sat_inc(retired);
                    pc      <= pc + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
